// File: rtl/fetch_buffer_pkg.sv
// Shared constants and slot record for the instruction fetch buffer.
// Each buffered slot holds one instruction plus its fetch exception and cookie.
package fetch_buffer_pkg;

    localparam logic [31:0] PC_RESET  = 32'h1c00_0000;
    localparam logic [31:0] INST_NOP  = 32'h0340_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // pc 32 + inst 32 + exception 7 + flag 2 + badv 32 + cookie 32
    localparam int FB_SLOT_W = 137;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
        logic [31:0] badv;
        logic [31:0] cookie;
    } fb_slot_t;

    // A packet splits into two slots only when it is exception-free and
    // the next fetch PC is exactly two instructions ahead.
    function automatic logic is_pair_packet(input logic [31:0] pc,
                                            input logic [31:0] pc_next,
                                            input logic [1:0]  excp_flag);
        return (excp_flag == 2'b00) && ((pc_next - pc) == 32'd8);
    endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Slot storage for the fetch buffer: two write ports, two asynchronous read ports.
// Write addresses are always distinct (wptr and wptr+1), so port order is irrelevant.
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we0,
    input  logic [PTR_W-1:0]     i_waddr0,
    input  logic [FB_SLOT_W-1:0] i_wdata0,
    input  logic                 i_we1,
    input  logic [PTR_W-1:0]     i_waddr1,
    input  logic [FB_SLOT_W-1:0] i_wdata1,
    input  logic [PTR_W-1:0]     i_raddr0,
    output logic [FB_SLOT_W-1:0] o_rdata0,
    input  logic [PTR_W-1:0]     i_raddr1,
    output logic [FB_SLOT_W-1:0] o_rdata1
);

    logic [FB_SLOT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-granular queue between the IF1->FIFO stage and decode.
// Splits fetch packets into slots and presents up to two instructions per cycle.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fifo_readygo,
    output logic        fifo_allowin,
    output logic        fetch_buf_full,
    input  logic [31:0] if1_fifo_pc,
    input  logic [31:0] if1_fifo_pc_next,
    input  logic [31:0] if1_fifo_inst0,
    input  logic [31:0] if1_fifo_inst1,
    input  logic [31:0] if1_fifo_icache_badv,
    input  logic [6:0]  if1_fifo_icache_exception,
    input  logic [1:0]  if1_fifo_icache_excp_flag,
    input  logic [31:0] if1_fifo_icache_cookie_out,
    input  logic        id_allowin,
    output logic        fb_valid0,
    output logic        fb_valid1,
    output logic [31:0] fb_pc0,
    output logic [31:0] fb_pc1,
    output logic [31:0] fb_inst0,
    output logic [31:0] fb_inst1,
    output logic [6:0]  fb_exception,
    output logic [1:0]  fb_excp_flag,
    output logic [31:0] fb_badv,
    output logic [31:0] fb_cookie
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_push;
    logic                 w_excp;
    logic                 w_pair;
    logic [1:0]           w_n_push;
    logic [1:0]           w_n_pop;
    logic [CNT_W:0]       w_count_next;
    logic [PTR_W-1:0]     w_wptr_inc;
    logic [PTR_W-1:0]     w_rptr_inc;
    fb_slot_t             w_slot_a;
    fb_slot_t             w_slot_b;
    fb_slot_t             w_head;
    fb_slot_t             w_next;
    logic [FB_SLOT_W-1:0] w_rdata0;
    logic [FB_SLOT_W-1:0] w_rdata1;
    logic                 w_next_unused;

    // Backpressure looks only at the registered count so it never forms a
    // combinational path from decode's id_allowin back to fetch.
    assign fifo_allowin   = (r_count <= CNT_W'(DEPTH - 2));
    assign fetch_buf_full = ~fifo_allowin;

    assign w_push     = fifo_readygo & fifo_allowin;
    assign w_excp     = (if1_fifo_icache_excp_flag != 2'b00);
    assign w_pair     = is_pair_packet(if1_fifo_pc, if1_fifo_pc_next,
                                       if1_fifo_icache_excp_flag);
    assign w_wptr_inc = r_wptr + PTR_W'(1);
    assign w_rptr_inc = r_rptr + PTR_W'(1);

    always_comb begin
        w_slot_a        = '0;
        w_slot_a.pc     = if1_fifo_pc;
        w_slot_a.inst   = if1_fifo_inst0;
        w_slot_a.cookie = if1_fifo_icache_cookie_out;
        if (w_excp) begin
            w_slot_a.exception = if1_fifo_icache_exception;
            w_slot_a.excp_flag = if1_fifo_icache_excp_flag;
            w_slot_a.badv      = if1_fifo_icache_badv;
        end

        w_slot_b        = '0;
        w_slot_b.pc     = if1_fifo_pc + 32'd4;
        w_slot_b.inst   = if1_fifo_inst1;
        w_slot_b.cookie = if1_fifo_icache_cookie_out;
    end

    always_comb begin
        w_n_push = 2'd0;
        if (w_push) begin
            w_n_push = w_pair ? 2'd2 : 2'd1;
        end
    end

    fetch_buffer_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .i_we0    (w_push),
        .i_waddr0 (r_wptr),
        .i_wdata0 (w_slot_a),
        .i_we1    (w_push & w_pair),
        .i_waddr1 (w_wptr_inc),
        .i_wdata1 (w_slot_b),
        .i_raddr0 (r_rptr),
        .o_rdata0 (w_rdata0),
        .i_raddr1 (w_rptr_inc),
        .o_rdata1 (w_rdata1)
    );

    assign w_head = fb_slot_t'(w_rdata0);
    assign w_next = fb_slot_t'(w_rdata1);

    // Slot 1 only contributes pc/inst/flag to decode; its remaining fields
    // become visible once it reaches the head.
    assign w_next_unused = ^{w_next.exception, w_next.badv, w_next.cookie};

    // An exception slot never pairs: it is held back from slot 1 and, at
    // the head, blocks its successor from issuing alongside it.
    assign fb_valid0 = (r_count != '0);
    assign fb_valid1 = (r_count >= CNT_W'(2)) &&
                       (w_head.excp_flag == 2'b00) &&
                       (w_next.excp_flag == 2'b00);

    always_comb begin
        fb_pc0       = PC_RESET;
        fb_inst0     = INST_NOP;
        fb_exception = 7'd0;
        fb_excp_flag = 2'd0;
        fb_badv      = ZERO_WORD;
        fb_cookie    = ZERO_WORD;
        fb_pc1       = PC_RESET;
        fb_inst1     = INST_NOP;
        if (fb_valid0) begin
            fb_pc0       = w_head.pc;
            fb_inst0     = w_head.inst;
            fb_exception = w_head.exception;
            fb_excp_flag = w_head.excp_flag;
            fb_badv      = w_head.badv;
            fb_cookie    = w_head.cookie;
        end
        if (fb_valid1) begin
            fb_pc1   = w_next.pc;
            fb_inst1 = w_next.inst;
        end
    end

    assign w_n_pop = id_allowin ? (2'(fb_valid0) + 2'(fb_valid1)) : 2'd0;

    assign w_count_next = {1'b0, r_count} + (CNT_W+1)'(w_n_push)
                        - (CNT_W+1)'(w_n_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_n_push);
            r_rptr  <= r_rptr + PTR_W'(w_n_pop);
            r_count <= w_count_next[CNT_W-1:0];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (w_count_next <= (CNT_W+1)'(DEPTH)));

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-granular queue between the IF1->FIFO stage register and decode.
- Accepts one fetch packet per cycle (1 or 2 instructions plus exception and cookie info) and splits it into per-instruction slots.
- Presents up to 2 instructions per cycle to decode.
- Drives the `fifo_allowin` / `fetch_buf_full` backpressure seen by the IF1->FIFO stage.

Parameters:
- DEPTH, 16, number of instruction slots; must be a power of 2 and >= 4.
- PTR_W, $clog2(DEPTH), read/write pointer width; count width is PTR_W+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  pipeline flush; clears the buffer
- fifo_readygo  in  1  upstream packet valid
- fifo_allowin  out  1  buffer can accept a 2-slot packet
- fetch_buf_full  out  1  equals !fifo_allowin
- if1_fifo_pc  in  32  packet PC (inst0)
- if1_fifo_pc_next  in  32  next fetch PC
- if1_fifo_inst0  in  32  first instruction
- if1_fifo_inst1  in  32  second instruction
- if1_fifo_icache_badv  in  32  faulting address
- if1_fifo_icache_exception  in  7  exception code
- if1_fifo_icache_excp_flag  in  2  nonzero = packet carries a fetch exception
- if1_fifo_icache_cookie_out  in  32  icache cookie
- id_allowin  in  1  decode accepts every valid output slot this cycle
- fb_valid0  out  1  slot 0 valid
- fb_valid1  out  1  slot 1 valid
- fb_pc0  out  32  slot 0 PC
- fb_pc1  out  32  slot 1 PC
- fb_inst0  out  32  slot 0 instruction
- fb_inst1  out  32  slot 1 instruction
- fb_exception  out  7  slot 0 exception code
- fb_excp_flag  out  2  slot 0 exception flag
- fb_badv  out  32  slot 0 badv
- fb_cookie  out  32  slot 0 cookie

Behaviour:
- Reset (async, rst=1): wptr=0, rptr=0, count=0, fb_valid0=fb_valid1=0, fifo_allowin=1, fetch_buf_full=0. All data outputs read PC_RESET / INST_NOP / 0.
- Push condition: fifo_readygo && fifo_allowin. Otherwise the packet is ignored; upstream holds it.
- Slots per pushed packet, n:
  - excp_flag != 0: n=1. One slot carrying inst0, exception, excp_flag, badv, cookie.
  - else pc_next - pc == 8: n=2. Slot A = (pc, inst0), slot B = (pc+4, inst1); both carry cookie, with exception/flag zero.
  - else: n=1 (pc, inst0).
- Push writes slots at wptr and wptr+1 (mod DEPTH); wptr += n.
- fifo_allowin = (count <= DEPTH-2), combinational from the registered count only. It never depends on same-cycle pop.
- Output slots (combinational from storage):
  - fb_valid0 = count >= 1.
  - fb_valid1 = count >= 2 && both head and head+1 have excp_flag == 0.
  - A slot carrying an exception is always issued alone, in slot 0.
  - Invalid slots drive inst INST_NOP, pc PC_RESET, fields 0.
  - fb_exception, fb_excp_flag, fb_badv, fb_cookie come from the head slot.
- Pop: when id_allowin, rptr += fb_valid0 + fb_valid1.
- Count update: count_next = count + pushed - popped. Simultaneous push and pop are legal in the same cycle, including on an empty buffer: a push into an empty buffer is not visible until the next cycle (1-cycle write-to-output latency).
- Wrap-around: pointers wrap modulo DEPTH. A 2-slot push at wptr=DEPTH-1 writes DEPTH-1 and 0.
- Flush (synchronous, priority over push and pop): next cycle wptr=rptr=count=0 and fb_valid0/1=0. The same-cycle push and pop are discarded.
- Invariant: count never exceeds DEPTH. Assert push implies count_next <= DEPTH.

Decomposition:
- PC_RESET, INST_NOP, zero come from the shared define header.
- Add FB_SLOT_W (slot record width: pc 32 + inst 32 + exception 7 + flag 2 + badv 32 + cookie 32) to the same header.
- Sub-module fetch_buffer_ram: DEPTH x FB_SLOT_W register array with two write ports (addresses wptr, wptr+1, per-port enable) and two asynchronous read ports (rptr, rptr+1).
- Pointer, count and slot-split logic stay in fetch_buffer.

Test Plan:
- Reset then one pair push: pc=0x1c000000, pc_next=0x1c000008, inst0=0x02800421, inst1=0x02800842 -> next cycle fb_valid0=fb_valid1=1, fb_pc1=0x1c000004; with id_allowin=1, count returns to 0.
- Single push: pc=0x1c000010, pc_next=0x1c000014 -> only fb_valid0; count=1.
- Exception packet: excp_flag=2'b01, exception=7'h08, badv=0x1c000020, queued behind one normal slot -> normal slot issues alone in slot 0, then exception slot issues alone next cycle with fb_badv=0x1c000020 and fb_valid1=0.
- Fill with id_allowin=0 (DEPTH=16): after 7 pair pushes count=14, fifo_allowin=1; after the 8th, count=16, fifo_allowin=0, fetch_buf_full=1. Further fifo_readygo pushes are ignored.
- Wrap: advance pointers to wptr=15 and push a pair -> slots at 15 and 0 read back in order with correct PCs.
- Flush while count=9 with simultaneous push and pop -> next cycle count=0, fb_valid0=0, fifo_allowin=1. Assert rst mid-operation -> outputs reach reset values immediately, without waiting for clk.
